data_access_unit: RTL and testbench

DATA_ACCESS_UNIT -- requirements
Module: data_access_unit

---
 rtl/data_access_unit.sv | 144 ++++++++++++++
 tb/tb_data_access_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_access_unit.sv
// Load/store unit between a single request/response port and a synchronous RAM.
// Handles lane steering, store byte enables, load extension and alignment faults.
module data_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               reqValid,
    output logic                               reqReady,
    input  logic [ADDR_W-1:0]                  reqAddr,
    input  logic [DATA_W-1:0]                  reqWdata,
    input  logic                               reqWrite,
    input  logic [1:0]                         reqSize,
    input  logic                               reqSign,
    output logic                               rspValid,
    input  logic                               rspReady,
    output logic [DATA_W-1:0]                  rspData,
    output logic [1:0]                         excCode,
    output logic [ADDR_W-1:0]                  badAddr,
    output logic                               ramEn,
    output logic [DATA_W/8-1:0]                ramWe,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0] ramAddr,
    output logic [DATA_W-1:0]                  ramWdata,
    input  logic [DATA_W-1:0]                  ramRdata
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              write_q;

    logic [1:0]        fault_code;
    logic [OFF_W-1:0]  off_in;
    logic [BYTES-1:0]  we_mask;
    logic [DATA_W-1:0] wdata_low;
    logic [DATA_W-1:0] lane_data;
    logic [DATA_W-1:0] load_ext;

    assign off_in   = reqAddr[OFF_W-1:0];
    assign reqReady = (state_q == IDLE);
    assign rspValid = (state_q == RESP);
    assign ramEn    = (state_q == ACCESS);

    // Illegal size wins over misalignment: a dword on a 32-bit bus has no aligned form.
    always_comb begin
        fault_code = 2'd0;
        if (reqSize == 2'd3 && DATA_W == 32)
            fault_code = 2'd3;
        else if ((reqSize == 2'd1 && reqAddr[0]) ||
                 (reqSize == 2'd2 && reqAddr[1:0] != 2'd0) ||
                 (reqSize == 2'd3 && reqAddr[2:0] != 3'd0))
            fault_code = reqWrite ? 2'd2 : 2'd1;
    end

    always_comb begin
        we_mask   = '0;
        wdata_low = '0;
        case (reqSize)
            2'd0: begin we_mask = BYTES'(1);     wdata_low = DATA_W'(reqWdata[7:0]);  end
            2'd1: begin we_mask = BYTES'(2'h3);  wdata_low = DATA_W'(reqWdata[15:0]); end
            2'd2: begin we_mask = BYTES'(4'hF);  wdata_low = DATA_W'(reqWdata[31:0]); end
            default: begin we_mask = '1;         wdata_low = reqWdata;                end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend from the access size.
    assign lane_data = ramRdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = lane_data;
        case (size_q)
            2'd0: load_ext = sign_q ? DATA_W'($signed(lane_data[7:0]))  : DATA_W'(lane_data[7:0]);
            2'd1: load_ext = sign_q ? DATA_W'($signed(lane_data[15:0])) : DATA_W'(lane_data[15:0]);
            2'd2: load_ext = sign_q ? DATA_W'($signed(lane_data[31:0])) : DATA_W'(lane_data[31:0]);
            default: load_ext = lane_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reqValid) state_d = (fault_code != 2'd0) ? RESP : ACCESS;
            ACCESS:  state_d = write_q ? RESP : WAIT;
            WAIT:    if (cnt_q == 3'd1) state_d = RESP;
            RESP:    if (rspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            off_q    <= '0;
            size_q   <= '0;
            sign_q   <= 1'b0;
            write_q  <= 1'b0;
            rspData  <= '0;
            excCode  <= '0;
            badAddr  <= '0;
            ramAddr  <= '0;
            ramWe    <= '0;
            ramWdata <= '0;
        end else begin
            case (state_q)
                IDLE: if (reqValid) begin
                    off_q   <= off_in;
                    size_q  <= reqSize;
                    sign_q  <= reqSign;
                    write_q <= reqWrite;
                    excCode <= fault_code;
                    badAddr <= (fault_code != 2'd0) ? reqAddr : '0;
                    rspData <= '0;
                    if (fault_code == 2'd0) begin
                        ramAddr  <= reqAddr[ADDR_W-1:OFF_W];
                        ramWe    <= reqWrite ? (we_mask << off_in) : '0;
                        ramWdata <= reqWrite ? (wdata_low << {off_in, 3'b000}) : '0;
                    end
                end
                ACCESS: begin
                    ramWe <= '0;
                    if (!write_q) cnt_q <= 3'(RAM_LATENCY);
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) rspData <= load_ext;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_access_unit.sv
// Scoreboard bench: a 32-bit/latency-1 unit and a 64-bit/latency-3 unit,
// checked against a byte-addressed reference memory model.
module tb_data_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;

    logic [1:0]            req_valid, req_write, req_sign, rsp_ready;
    logic [1:0]            req_ready, rsp_valid, ram_en;
    logic [1:0][31:0]      req_addr, bad_addr, ram_addr;
    logic [1:0][63:0]      req_wdata, rsp_data, ram_wdata;
    logic [1:0][1:0]       req_size, exc_code;
    logic [1:0][7:0]       ram_we;
    logic [1:0][2:0][63:0] rpipe;

    logic [31:0] rd32, wd32;
    logic [3:0]  we32;
    logic [29:0] ra32;
    logic [63:0] rd64, wd64;
    logic [7:0]  we64;
    logic [28:0] ra64;

    assign rsp_data[0]  = {32'd0, rd32};
    assign rsp_data[1]  = rd64;
    assign ram_wdata[0] = {32'd0, wd32};
    assign ram_wdata[1] = wd64;
    assign ram_we[0]    = {4'd0, we32};
    assign ram_we[1]    = we64;
    assign ram_addr[0]  = {2'd0, ra32};
    assign ram_addr[1]  = {3'd0, ra64};

    data_access_unit #(.DATA_W(32), .ADDR_W(32), .RAM_LATENCY(1)) u32 (
        .clk(clk), .resetn(resetn),
        .reqValid(req_valid[0]), .reqReady(req_ready[0]), .reqAddr(req_addr[0]),
        .reqWdata(req_wdata[0][31:0]), .reqWrite(req_write[0]), .reqSize(req_size[0]),
        .reqSign(req_sign[0]), .rspValid(rsp_valid[0]), .rspReady(rsp_ready[0]),
        .rspData(rd32), .excCode(exc_code[0]), .badAddr(bad_addr[0]),
        .ramEn(ram_en[0]), .ramWe(we32), .ramAddr(ra32), .ramWdata(wd32),
        .ramRdata(rpipe[0][0][31:0]));

    data_access_unit #(.DATA_W(64), .ADDR_W(32), .RAM_LATENCY(3)) u64 (
        .clk(clk), .resetn(resetn),
        .reqValid(req_valid[1]), .reqReady(req_ready[1]), .reqAddr(req_addr[1]),
        .reqWdata(req_wdata[1]), .reqWrite(req_write[1]), .reqSize(req_size[1]),
        .reqSign(req_sign[1]), .rspValid(rsp_valid[1]), .rspReady(rsp_ready[1]),
        .rspData(rd64), .excCode(exc_code[1]), .badAddr(bad_addr[1]),
        .ramEn(ram_en[1]), .ramWe(we64), .ramAddr(ra64), .ramWdata(wd64),
        .ramRdata(rpipe[1][2]));

    typedef struct {
        int          d;
        logic [63:0] data;
        logic [1:0]  exc;
        logic [31:0] bad;
        int          t;
        int          lat;
    } rsp_exp_t;

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [7:0]  we;
        logic [63:0] wdata;
        logic        wr;
        int          t;
    } ram_exp_t;

    rsp_exp_t    rsp_q[$];
    ram_exp_t    ram_q[$];
    logic [7:0]  ref_mem [2][8192];
    logic [7:0]  ram_mem [2][8192];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ready_mode = 2;
    logic [1:0]  active = '0;
    logic [1:0]  prev_hs = '0;
    logic [63:0] hold_data [2];
    logic [1:0]  hold_exc [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] rd_word(input int d, input int base);
        logic [63:0] w;
        w = '0;
        for (int b = 0; b < (d != 0 ? 8 : 4); b++) w[8*b +: 8] = ram_mem[d][(base + b) % 8192];
        return w;
    endfunction

    // RAM model: word-wide synchronous RAM with a per-instance read delay line.
    initial begin
        rpipe = '0;
        forever begin
            @(posedge clk);
            if (!resetn) rpipe <= '0;
            else for (int d = 0; d < 2; d++) begin
                rpipe[d][2] <= rpipe[d][1];
                rpipe[d][1] <= rpipe[d][0];
                rpipe[d][0] <= ram_en[d] ? rd_word(d, int'(ram_addr[d]) * (d != 0 ? 8 : 4)) : 64'd0;
                if (ram_en[d])
                    for (int b = 0; b < 8; b++)
                        if (ram_we[d][b])
                            ram_mem[d][(int'(ram_addr[d]) * (d != 0 ? 8 : 4) + b) % 8192] <= ram_wdata[d][8*b +: 8];
            end
        end
    end

    initial begin
        rsp_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                rsp_ready[d] = (ready_mode == 1) ? 1'b0 :
                               (ready_mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: RAM transactions and responses are popped and compared as they appear.
    initial begin
        rsp_exp_t e;
        ram_exp_t m;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!resetn) begin
                    active[d]  = 1'b0;
                    prev_hs[d] = 1'b0;
                end else begin
                    if (prev_hs[d]) begin
                        chk("ready_after_rsp", 64'(req_ready[d]), 64'd1);
                        prev_hs[d] = 1'b0;
                    end
                    if (ram_en[d]) begin
                        if (ram_q.size() == 0) chk("ram_en_unexpected", 64'd1, 64'd0);
                        else begin
                            m = ram_q.pop_front();
                            chk("ram_dut", 64'(d), 64'(m.d));
                            chk("ram_lat", 64'(cyc - m.t), 64'd1);
                            chk("ram_addr", 64'(ram_addr[d]), 64'(m.addr));
                            chk("ram_we", 64'(ram_we[d]), 64'(m.we));
                            if (m.wr) chk("ram_wdata", ram_wdata[d], m.wdata);
                        end
                    end
                    if (rsp_valid[d]) begin
                        if (!active[d]) begin
                            if (rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
                            else begin
                                e = rsp_q.pop_front();
                                chk("rsp_dut", 64'(d), 64'(e.d));
                                chk("rsp_lat", 64'(cyc - e.t), 64'(e.lat));
                                chk("rsp_data", rsp_data[d], e.data);
                                chk("rsp_exc", 64'(exc_code[d]), 64'(e.exc));
                                if (e.exc != 2'd0) chk("rsp_bad_addr", 64'(bad_addr[d]), 64'(e.bad));
                            end
                            hold_data[d] = rsp_data[d];
                            hold_exc[d]  = exc_code[d];
                            active[d]    = 1'b1;
                        end else begin
                            chk("rsp_data_stable", rsp_data[d], hold_data[d]);
                            chk("rsp_exc_stable", 64'(exc_code[d]), 64'(hold_exc[d]));
                        end
                        chk("req_ready_busy", 64'(req_ready[d]), 64'd0);
                        if (rsp_ready[d]) begin
                            active[d]  = 1'b0;
                            prev_hs[d] = 1'b1;
                        end
                    end else if (active[d]) begin
                        chk("rsp_dropped", 64'd0, 64'd1);
                        active[d] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic poke(input int d, input int addr, input logic [63:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            ref_mem[d][addr + i] = val[8*i +: 8];
            ram_mem[d][addr + i] = val[8*i +: 8];
        end
    endtask

    // Drives one request, waits for acceptance and pushes what the model expects.
    task automatic issue(input int d, input logic [31:0] addr, input logic [63:0] wdata,
                         input logic wr, input logic [1:0] size, input logic sg, output int waited);
        rsp_exp_t    r;
        ram_exp_t    m;
        int          nb, n, off;
        logic [63:0] v;
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_write[d] = wr;
        req_size[d]  = size;
        req_sign[d]  = sg;
        waited = 0;
        @(negedge clk);
        while (!req_ready[d] && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 100) begin
            chk("accept_timeout", 64'd1, 64'd0);
            req_valid[d] = 1'b0;
            return;
        end
        nb = (d != 0) ? 8 : 4;
        n  = 1 << size;
        off = int'(addr) % nb;
        r.d = d; r.t = cyc; r.data = '0; r.bad = '0;
        if (size == 2'd3 && nb == 4)  r.exc = 2'd3;
        else if (int'(addr) % n != 0) r.exc = wr ? 2'd2 : 2'd1;
        else                          r.exc = 2'd0;
        if (r.exc != 2'd0) begin
            r.bad = addr;
            r.lat = 1;
        end else begin
            m.d = d; m.addr = addr / nb; m.wr = wr; m.t = cyc; m.we = '0; m.wdata = '0;
            if (wr) begin
                for (int i = 0; i < n; i++) begin
                    m.we[off + i] = 1'b1;
                    m.wdata[8*(off + i) +: 8] = wdata[8*i +: 8];
                    ref_mem[d][int'(addr) + i] = wdata[8*i +: 8];
                end
                r.lat = 2;
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[d][int'(addr) + i];
                if (sg && v[8*n - 1])
                    for (int i = n; i < nb; i++) v[8*i +: 8] = 8'hFF;
                r.data = v;
                r.lat  = 2 + ((d != 0) ? 3 : 1);
            end
            ram_q.push_back(m);
        end
        rsp_q.push_back(r);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        req_wdata[d] = {$urandom, $urandom};
        req_write[d] = 1'($urandom_range(0, 1));
        req_size[d]  = 2'($urandom_range(0, 3));
        req_sign[d]  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || active != 2'b00) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'(rsp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int d, input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready[d]), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid[d]), 64'd0);
        chk({tag, "_ram_en"},    64'(ram_en[d]),    64'd0);
        chk({tag, "_rsp_data"},  rsp_data[d],       64'd0);
        chk({tag, "_exc"},       64'(exc_code[d]),  64'd0);
        chk({tag, "_bad_addr"},  64'(bad_addr[d]),  64'd0);
        chk({tag, "_ram_addr"},  64'(ram_addr[d]),  64'd0);
        chk({tag, "_ram_we"},    64'(ram_we[d]),    64'd0);
        chk({tag, "_ram_wdata"}, ram_wdata[d],      64'd0);
    endtask

    task automatic random_phase(input int d, input int count);
        logic [31:0] a;
        logic [1:0]  sz;
        int          w;
        for (int k = 0; k < count; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 8184);
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
            issue(d, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sz,
                  1'($urandom_range(0, 1)), w);
        end
    endtask

    initial begin
        int w;
        int n;
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        resetn = 1'b0;
        req_valid = '0; req_write = '0; req_sign = '0;
        req_addr = '0; req_wdata = '0; req_size = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8192; i++) begin
                ref_mem[d][i] = 8'($urandom);
                ram_mem[d][i] = ref_mem[d][i];
            end
        repeat (3) @(posedge clk);
        #1;
        check_zero(0, "reset32");
        check_zero(1, "reset64");
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;

        // 32-bit directed vectors
        issue(0, 32'h1003, 64'hAB, 1'b1, 2'd0, 1'b0, w);
        drain();
        poke(0, 32'h1000, 64'h80FF0000, 4);
        issue(0, 32'h1003, 64'h0, 1'b0, 2'd0, 1'b1, w);
        issue(0, 32'h1003, 64'h0, 1'b0, 2'd0, 1'b0, w);
        issue(0, 32'h1001, 64'h0, 1'b0, 2'd1, 1'b0, w);
        issue(0, 32'h1000, 64'h0, 1'b0, 2'd3, 1'b0, w);
        issue(0, 32'h1002, 64'h1234, 1'b1, 2'd2, 1'b0, w);
        issue(0, 32'h1006, 64'hBEEF, 1'b1, 2'd1, 1'b0, w);
        issue(0, 32'h1004, 64'h0, 1'b0, 2'd2, 1'b1, w);
        drain();

        // Consumer stalls for three cycles on a word load
        ready_mode = 1;
        issue(0, 32'h1000, 64'h0, 1'b0, 2'd2, 1'b0, w);
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("stall_rsp_timeout", 64'd1, 64'd0);
        repeat (3) @(posedge clk);
        ready_mode = 2;
        drain();

        ready_mode = 0;
        random_phase(0, 80);
        drain();

        // 64-bit directed vectors
        ready_mode = 2;
        poke(1, 32'h08, 64'h8001_0000_0000_0000, 8);
        issue(1, 32'h0E, 64'h0, 1'b0, 2'd1, 1'b1, w);
        issue(1, 32'h10, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd3, 1'b0, w);
        issue(1, 32'h10, 64'h0, 1'b0, 2'd3, 1'b0, w);
        issue(1, 32'h14, 64'h0, 1'b0, 2'd2, 1'b1, w);
        issue(1, 32'h14, 64'h0, 1'b1, 2'd3, 1'b0, w);
        drain();

        ready_mode = 0;
        random_phase(1, 80);
        drain();

        // Reset while a latency-3 load sits in WAIT
        ready_mode = 2;
        issue(1, 32'h100, 64'h0, 1'b0, 2'd3, 1'b0, w);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check_zero(1, "rst_wait");
        chk("rst_ram_q_empty", 64'(ram_q.size()), 64'd0);
        rsp_q.delete();
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        issue(1, 32'h200, {$urandom, $urandom}, 1'b1, 2'd3, 1'b0, w);
        chk("accept_first_cycle", 64'(w), 64'd0);
        issue(1, 32'h200, 64'h0, 1'b0, 2'd2, 1'b1, w);
        drain();
        repeat (5) @(posedge clk);
        chk("final_rsp_q_empty", 64'(rsp_q.size()), 64'd0);
        chk("final_ram_q_empty", 64'(ram_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
